joy_serializer: RTL and testbench

Responder end of the serial joystick link: emulates the two-pad parallel-in/serial-out shift board that the joystick decoder clocks through JOY_CLK / JOY_LOAD / JOY_DATA. Samples 12 active-low button lines, debounces them, snapshots them on load, and shifts them out MSB-first on the master's clock. Used as a board-side replacement for the shift-register hardware and as a loopback partner for decoder verification.

---
 rtl/joy_serializer_if.sv | 11 +
 rtl/joy_serializer.sv | 144 ++++++++++++++
 tb/tb_joy_serializer.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/joy_serializer_if.sv
// Serial joystick link between decoder (master) and shift-board responder (slave).
// Latency: none, plain wires.
// Backpressure: none; the master paces the link with joy_clk / joy_load_n.
interface joy_serializer_if;
  logic joy_clk;     // shift clock from the decoder
  logic joy_load_n;  // parallel load, active-low
  logic joy_data;    // serial data back to the decoder

  modport master (output joy_clk, output joy_load_n, input joy_data);
  modport slave  (input joy_clk, input joy_load_n, output joy_data);
endinterface

// File: rtl/joy_serializer.sv
// Two-pad '165-style shift board: debounced button snapshot, MSB-first on joy_clk.
// Latency: load -> joy_data 3 clk, joy_clk rise -> joy_data 3 clk, buttons DEBOUNCE_CYCLES+3 clk.
// Backpressure: none; the decoder owns the pacing, extra shift edges clock out 1s.
module joy_serializer #(
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int FRAME_BITS      = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [5:0]        joy1_n,
  input  logic [5:0]        joy2_n,
  joy_serializer_if.slave   link,
  output logic [11:0]       buttons_n,
  output logic              frame_strobe
);

  localparam int CNT_W = $clog2(FRAME_BITS + 1);

  // The second load_n synchronizer stage doubles as the state register:
  // synced load_n = 0 means LOAD, 1 means SHIFT.
  typedef enum logic {ST_LOAD = 1'b0, ST_SHIFT = 1'b1} state_t;

  logic [11:0]      btn_s1_q, btn_s2_q;
  logic             load_s1_q;
  state_t           state_q;
  logic             jclk_s1_q, jclk_s2_q, jclk_s3_q;
  logic             jclk_rise;
  logic [11:0]      stable_n;
  logic [15:0]      snapshot;
  logic [15:0]      sr_q, sr_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic             strobe_q, strobe_d;
  logic             joy_data_q;

  // Two-flop synchronizers for buttons and load, three flops on joy_clk for edge detect.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      btn_s1_q  <= '1;
      btn_s2_q  <= '1;
      load_s1_q <= 1'b1;
      state_q   <= ST_SHIFT;
      jclk_s1_q <= 1'b1;
      jclk_s2_q <= 1'b1;
      jclk_s3_q <= 1'b1;
    end else begin
      btn_s1_q  <= {joy2_n, joy1_n};
      btn_s2_q  <= btn_s1_q;
      load_s1_q <= link.joy_load_n;
      state_q   <= load_s1_q ? ST_SHIFT : ST_LOAD;
      jclk_s1_q <= link.joy_clk;
      jclk_s2_q <= jclk_s1_q;
      jclk_s3_q <= jclk_s2_q;
    end
  end

  assign jclk_rise = jclk_s2_q & ~jclk_s3_q;

  generate
    if (DEBOUNCE_CYCLES == 0) begin : g_no_db
      assign stable_n = btn_s2_q;
    end else begin : g_db
      localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
      localparam logic [DB_W-1:0] DB_MAX = DB_W'(DEBOUNCE_CYCLES);

      logic [DB_W-1:0] db_cnt_q [12];
      logic [11:0]     stable_q;

      // Per-button counter: the stable value only moves after the synced input
      // has disagreed with it for DEBOUNCE_CYCLES consecutive clocks.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          stable_q <= '1;
          for (int i = 0; i < 12; i++) db_cnt_q[i] <= '0;
        end else begin
          for (int i = 0; i < 12; i++) begin
            if (btn_s2_q[i] == stable_q[i]) begin
              db_cnt_q[i] <= '0;
            end else if (db_cnt_q[i] == DB_MAX) begin
              stable_q[i] <= btn_s2_q[i];
              db_cnt_q[i] <= '0;
            end else begin
              db_cnt_q[i] <= db_cnt_q[i] + DB_W'(1);
            end
          end
        end
      end

      assign stable_n = stable_q;
    end
  endgenerate

  // Frame order, bit 15 first: j1 {up,down,left,right,fire1,fire2}, 11, j2 same, 11.
  assign snapshot = {stable_n[0], stable_n[1], stable_n[2], stable_n[3],
                     stable_n[4], stable_n[5], 2'b11,
                     stable_n[6], stable_n[7], stable_n[8], stable_n[9],
                     stable_n[10], stable_n[11], 2'b11};

  // Next-state for the shift register: transparent reload while loading,
  // otherwise shift in 1s on joy_clk rises with a saturating bit counter.
  always_comb begin
    sr_d      = sr_q;
    bit_cnt_d = bit_cnt_q;
    strobe_d  = 1'b0;
    case (state_q)
      ST_LOAD: begin
        sr_d      = snapshot;
        bit_cnt_d = '0;
      end
      ST_SHIFT: begin
        if (jclk_rise) begin
          sr_d = {sr_q[14:0], 1'b1};
          if (bit_cnt_q != CNT_W'(FRAME_BITS)) begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
            strobe_d  = (bit_cnt_q == CNT_W'(FRAME_BITS - 1));
          end
        end
      end
      default: begin
        sr_d      = '1;
        bit_cnt_d = '0;
      end
    endcase
  end

  // joy_data is registered from the next MSB so it always mirrors sr_q[15].
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sr_q       <= '1;
      bit_cnt_q  <= '0;
      strobe_q   <= 1'b0;
      joy_data_q <= 1'b1;
    end else begin
      sr_q       <= sr_d;
      bit_cnt_q  <= bit_cnt_d;
      strobe_q   <= strobe_d;
      joy_data_q <= sr_d[15];
    end
  end

  assign link.joy_data = joy_data_q;
  assign buttons_n     = stable_n;
  assign frame_strobe  = strobe_q;

endmodule

// File: tb/tb_joy_serializer.sv
// Bench for joy_serializer: table-driven frames with a bit scoreboard plus corner sequences.
// Two instances: debounce 4 for the link tests, debounce 8 for the debounce timing.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_joy_serializer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [5:0]  j1, j2;
  logic        jclk, jload_n;
  logic [11:0] btn4, btn8;
  logic        strobe4, strobe8;

  joy_serializer_if link4();
  joy_serializer_if link8();

  assign link4.joy_clk    = jclk;
  assign link4.joy_load_n = jload_n;
  assign link8.joy_clk    = jclk;
  assign link8.joy_load_n = jload_n;

  joy_serializer #(.DEBOUNCE_CYCLES(4), .FRAME_BITS(16)) dut4 (
    .clk(clk), .reset_n(rst_n), .joy1_n(j1), .joy2_n(j2),
    .link(link4), .buttons_n(btn4), .frame_strobe(strobe4));

  joy_serializer #(.DEBOUNCE_CYCLES(8), .FRAME_BITS(16)) dut8 (
    .clk(clk), .reset_n(rst_n), .joy1_n(j1), .joy2_n(j2),
    .link(link8), .buttons_n(btn8), .frame_strobe(strobe8));

  int checks = 0;
  int errors = 0;
  int strobe_hi = 0;   // number of clk cycles frame_strobe of dut4 was high
  bit exp_q[$];        // expected serial bits, MSB first

  always @(posedge clk) if (strobe4) strobe_hi <= strobe_hi + 1;

  typedef struct {
    logic [5:0]  j1;
    logic [5:0]  j2;
    logic [15:0] frame;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic jedge();
    jclk = 1'b1; tick(10);
    jclk = 1'b0; tick(10);
  endtask

  // Queue the expected frame, pulse load and confirm bit 15 shows while loading.
  task automatic load_pulse(input logic [15:0] f);
    exp_q.delete();
    for (int i = 15; i >= 0; i--) exp_q.push_back(f[i]);
    jload_n = 1'b0; tick(6);
    chk("load_bit15", 16'(link4.joy_data), 16'(f[15]));
    jload_n = 1'b1; tick(6);
  endtask

  // Shift n bits, comparing each against the scoreboard before its edge.
  task automatic shift_n(input int n, input string name);
    bit b;
    for (int e = 0; e < n; e++) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL %s_underflow: got empty expected bit", name);
      end else begin
        b = exp_q.pop_front();
        chk(name, 16'(link4.joy_data), 16'(b));
      end
      jedge();
    end
  endtask

  // Full 16-edge frame: no strobe through edge 15, exactly one strobe clk after edge 16.
  task automatic shift_frame(input string name);
    int base;
    base = strobe_hi;
    shift_n(15, name);
    chk({name, "_no_early_strobe"}, 16'(strobe_hi - base), 16'd0);
    shift_n(1, name);
    chk({name, "_strobe_once"}, 16'(strobe_hi - base), 16'd1);
    chk({name, "_tail_one"}, 16'(link4.joy_data), 16'd1);
  endtask

  initial begin
    vecs[0] = '{j1: 6'b111110, j2: 6'b011111, frame: 16'h7FFB};
    vecs[1] = '{j1: 6'b111111, j2: 6'b111111, frame: 16'hFFFF};
    vecs[2] = '{j1: 6'b000000, j2: 6'b000000, frame: 16'h0303};
    vecs[3] = '{j1: 6'b101010, j2: 6'b010101, frame: 16'h57AB};
    vecs[4] = '{j1: 6'b111100, j2: 6'b110111, frame: 16'h3FEF};

    // Reset with random inputs.
    rst_n   = 1'b0;
    j1      = 6'($urandom);
    j2      = 6'($urandom);
    jclk    = 1'($urandom);
    jload_n = 1'($urandom);
    tick(3);
    chk("rst_joy_data", 16'(link4.joy_data), 16'd1);
    chk("rst_buttons4", 16'(btn4), 16'h0FFF);
    chk("rst_buttons8", 16'(btn8), 16'h0FFF);
    chk("rst_strobe", 16'(strobe4), 16'd0);
    rst_n = 1'b1;
    tick(1);
    chk("rel_joy_data", 16'(link4.joy_data), 16'd1);
    chk("rel_buttons4", 16'(btn4), 16'h0FFF);
    chk("rel_strobe", 16'(strobe4), 16'd0);

    j1 = '1; j2 = '1; jclk = 1'b0; jload_n = 1'b1;
    tick(30);

    // Table-driven frames.
    for (int v = 0; v < 5; v++) begin
      j1 = vecs[v].j1;
      j2 = vecs[v].j2;
      tick(20);
      chk("buttons", 16'(btn4), 16'({vecs[v].j2, vecs[v].j1}));
      load_pulse(vecs[v].frame);
      shift_frame("frame_bit");
    end

    // Over-clock: four more edges give 1s and no strobe; a new load restores bit 15.
    begin
      int base;
      base = strobe_hi;
      for (int e = 0; e < 4; e++) begin
        jedge();
        chk("overclk_data", 16'(link4.joy_data), 16'd1);
      end
      chk("overclk_no_strobe", 16'(strobe_hi - base), 16'd0);
    end
    load_pulse(vecs[4].frame);
    shift_frame("reload_bit");

    // Load priority: edges while loading neither shift nor count; j1 up is tracked.
    j1 = '1; j2 = '1;
    tick(20);
    begin
      int base;
      base = strobe_hi;
      jload_n = 1'b0; tick(6);
      j1[0] = 1'b0; jclk = 1'b1; tick(10);
      chk("lp_press1", 16'(link4.joy_data), 16'd0);
      j1[0] = 1'b1; jclk = 1'b0; tick(10);
      chk("lp_release", 16'(link4.joy_data), 16'd1);
      j1[0] = 1'b0; jclk = 1'b1; tick(10);
      chk("lp_press2", 16'(link4.joy_data), 16'd0);
      jclk = 1'b0; tick(10);
      jclk = 1'b1; tick(10);
      chk("lp_hold", 16'(link4.joy_data), 16'd0);
      jclk = 1'b0; tick(10);
      chk("lp_no_strobe", 16'(strobe_hi - base), 16'd0);
      exp_q.delete();
      for (int i = 15; i >= 0; i--) exp_q.push_back(i != 15);  // 16'h7FFF
      jload_n = 1'b1; tick(6);
      shift_frame("lp_bit");
    end

    // Asynchronous reset mid-frame.
    j1 = 6'b111110; j2 = 6'b011111;
    tick(20);
    load_pulse(16'h7FFB);
    shift_n(7, "mid_bit");
    chk("mid_buttons_before", 16'(btn4), 16'h07FE);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_data", 16'(link4.joy_data), 16'd1);
    chk("mid_rst_buttons", 16'(btn4), 16'h0FFF);
    chk("mid_rst_strobe", 16'(strobe4), 16'd0);
    tick(2);
    rst_n = 1'b1;
    tick(2);
    jedge();
    chk("post_rst_first_edge", 16'(link4.joy_data), 16'd1);
    tick(20);
    load_pulse(16'h7FFB);
    shift_frame("post_rst_bit");

    // Debounce timing on the DEBOUNCE_CYCLES = 8 instance.
    j1 = '1; j2 = '1;
    tick(30);
    chk("db_idle", 16'(btn8), 16'h0FFF);
    j2[0] = 1'b0;
    tick(5);
    j2[0] = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      tick(1);
      chk("db_glitch", 16'(btn8), 16'h0FFF);
    end
    j2[0] = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      tick(1);
      chk("db_press", 16'(btn8[6]), (k >= 11) ? 16'd0 : 16'd1);
    end
    j2[0] = 1'b1;
    for (int k = 1; k <= 13; k++) begin
      tick(1);
      chk("db_release", 16'(btn8[6]), (k >= 11) ? 16'd1 : 16'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
